// File: rtl/memory_stage.sv
// Memory pipeline stage: M pipeline register, data-memory request/response FSM,
// store lane alignment, load extension and forwarding mux.
module memory_stage (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] alu_result_e_i,
   input  logic [31:0] write_data_e_i,
   input  logic [31:0] pc_target_e_i,
   input  logic [31:0] pc_plus4_e_i,
   input  logic [31:0] imm_ext_e_i,
   input  logic [4:0]  rd_e_i,
   input  logic [2:0]  width_src_e_i,
   input  logic [2:0]  result_src_e_i,
   input  logic        valid_e_i,
   input  logic        reg_write_e_i,
   input  logic        mem_write_e_i,
   input  logic        stall_m_i,
   input  logic        flush_m_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_ready_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [31:0] forward_data_m_o,
   output logic [31:0] read_data_m_o,
   output logic [4:0]  rd_m_o,
   output logic        reg_write_m_o,
   output logic [2:0]  result_src_m_o,
   output logic        valid_m_o,
   output logic [31:0] pc_plus4_m_o,
   output logic        mem_busy_o,
   output logic        misalign_o
);

   localparam logic [2:0] RS_ALU = 3'b000, RS_MEM = 3'b001, RS_PC4 = 3'b010,
                          RS_IMM = 3'b011, RS_PCT = 3'b100;
   localparam logic [2:0] W_W = 3'b000, W_H = 3'b001, W_B = 3'b010,
                          W_HU = 3'b011, W_BU = 3'b100;

   // DRAIN absorbs the response of a load flushed after its request was accepted
   typedef enum logic [2:0] {IDLE, REQ, RSP, DONE, DRAIN} state_t;
   state_t state;

   logic [31:0] alu_result_m, write_data_m, pc_target_m, imm_ext_m;
   logic [2:0]  width_m;
   logic        mem_write_m;
   logic        load_m, acc_e;
   logic [31:0] lane, load_ext;
   logic [3:0]  be_raw;

   function automatic logic misaligned(input logic [2:0] w, input logic [1:0] a);
      case (w)
         W_H, W_HU: return a[0];
         W_B, W_BU: return 1'b0;
         default:   return a != 2'b00;
      endcase
   endfunction

   function automatic logic is_mem(input logic v, input logic mw, input logic [2:0] rs);
      return v & (mw | (rs == RS_MEM));
   endfunction

   assign mem_busy_o = (state == REQ) || (state == RSP) || (state == DRAIN);
   assign load_m     = ~stall_m_i & ~mem_busy_o;
   assign acc_e      = is_mem(valid_e_i, mem_write_e_i, result_src_e_i)
                       & ~misaligned(width_src_e_i, alu_result_e_i[1:0]);
   assign misalign_o = is_mem(valid_m_o, mem_write_m, result_src_m_o)
                       & misaligned(width_m, alu_result_m[1:0]);

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_m_i) begin
         alu_result_m   <= '0;
         write_data_m   <= '0;
         pc_target_m    <= '0;
         pc_plus4_m_o   <= '0;
         imm_ext_m      <= '0;
         rd_m_o         <= '0;
         width_m        <= '0;
         result_src_m_o <= '0;
         valid_m_o      <= 1'b0;
         reg_write_m_o  <= 1'b0;
         mem_write_m    <= 1'b0;
      end else if (load_m) begin
         alu_result_m   <= alu_result_e_i;
         write_data_m   <= write_data_e_i;
         pc_target_m    <= pc_target_e_i;
         pc_plus4_m_o   <= pc_plus4_e_i;
         imm_ext_m      <= imm_ext_e_i;
         rd_m_o         <= rd_e_i;
         width_m        <= width_src_e_i;
         result_src_m_o <= result_src_e_i;
         valid_m_o      <= valid_e_i;
         reg_write_m_o  <= reg_write_e_i;
         mem_write_m    <= mem_write_e_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state         <= IDLE;
         read_data_m_o <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (flush_m_i)   state <= IDLE;
               else if (load_m) state <= acc_e ? REQ : IDLE;
            end
            REQ: begin
               if (dmem_ready_i)
                  state <= flush_m_i ? (mem_write_m ? IDLE : DRAIN)
                                     : (mem_write_m ? DONE : RSP);
               else if (flush_m_i)
                  state <= IDLE;
            end
            RSP: begin
               if (dmem_rvalid_i) begin
                  if (flush_m_i) state <= IDLE;
                  else begin
                     state         <= DONE;
                     read_data_m_o <= load_ext;
                  end
               end else if (flush_m_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: if (dmem_rvalid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign dmem_req_o  = (state == REQ);
   assign dmem_we_o   = mem_write_m;
   assign dmem_addr_o = {alu_result_m[31:2], 2'b00};
   assign dmem_be_o   = dmem_req_o ? be_raw : '0;

   always_comb begin
      be_raw       = 4'b1111;
      dmem_wdata_o = write_data_m;
      case (width_m)
         W_B, W_BU: begin
            be_raw       = 4'b0001 << alu_result_m[1:0];
            dmem_wdata_o = {4{write_data_m[7:0]}};
         end
         W_H, W_HU: begin
            be_raw       = 4'b0011 << alu_result_m[1:0];
            dmem_wdata_o = {2{write_data_m[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane = dmem_rdata_i >> {alu_result_m[1:0], 3'b000};
      case (width_m)
         W_B:     load_ext = {{24{lane[7]}}, lane[7:0]};
         W_H:     load_ext = {{16{lane[15]}}, lane[15:0]};
         W_BU:    load_ext = {24'd0, lane[7:0]};
         W_HU:    load_ext = {16'd0, lane[15:0]};
         default: load_ext = dmem_rdata_i;
      endcase
   end

   always_comb begin
      case (result_src_m_o)
         RS_ALU, RS_MEM: forward_data_m_o = alu_result_m;
         RS_PC4:         forward_data_m_o = pc_plus4_m_o;
         RS_IMM:         forward_data_m_o = imm_ext_m;
         RS_PCT:         forward_data_m_o = pc_target_m;
         default:        forward_data_m_o = '0;
      endcase
   end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus queues expected dmem requests and
// load results, a negedge monitor pops and compares when the DUT presents them.
module tb_memory_stage;

   logic        clk, reset_i;
   logic [31:0] alu_result_e_i, write_data_e_i, pc_target_e_i, pc_plus4_e_i, imm_ext_e_i;
   logic [4:0]  rd_e_i;
   logic [2:0]  width_src_e_i, result_src_e_i;
   logic        valid_e_i, reg_write_e_i, mem_write_e_i, stall_m_i, flush_m_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ready_i, dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] forward_data_m_o, read_data_m_o, pc_plus4_m_o;
   logic [4:0]  rd_m_o;
   logic        reg_write_m_o, valid_m_o, mem_busy_o, misalign_o;
   logic [2:0]  result_src_m_o;

   memory_stage dut (
      .clk_i(clk), .reset_i(reset_i),
      .alu_result_e_i(alu_result_e_i), .write_data_e_i(write_data_e_i),
      .pc_target_e_i(pc_target_e_i), .pc_plus4_e_i(pc_plus4_e_i),
      .imm_ext_e_i(imm_ext_e_i), .rd_e_i(rd_e_i),
      .width_src_e_i(width_src_e_i), .result_src_e_i(result_src_e_i),
      .valid_e_i(valid_e_i), .reg_write_e_i(reg_write_e_i), .mem_write_e_i(mem_write_e_i),
      .stall_m_i(stall_m_i), .flush_m_i(flush_m_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
      .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .forward_data_m_o(forward_data_m_o), .read_data_m_o(read_data_m_o),
      .rd_m_o(rd_m_o), .reg_write_m_o(reg_write_m_o), .result_src_m_o(result_src_m_o),
      .valid_m_o(valid_m_o), .pc_plus4_m_o(pc_plus4_m_o),
      .mem_busy_o(mem_busy_o), .misalign_o(misalign_o)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];
   int          checks = 0;
   int          failures = 0;
   logic        rd_pending = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // monitor: request handshakes and load results
   always @(negedge clk) begin
      if (rd_pending) begin
         rd_pending = 1'b0;
         if (rd_q.size() == 0) chk("rdata_unexpected", read_data_m_o, 32'hxxxx_xxxx);
         else chk("read_data", read_data_m_o, rd_q.pop_front());
      end
      if (!reset_i && mem_busy_o && dmem_rvalid_i && !dmem_req_o) rd_pending = 1'b1;
      if (dmem_req_o && dmem_ready_i) begin
         if (req_q.size() == 0) begin
            chk("req_unexpected", dmem_addr_o, 32'hxxxx_xxxx);
         end else begin
            req_t e;
            e = req_q.pop_front();
            chk("req_we", {31'd0, dmem_we_o}, {31'd0, e.we});
            chk("req_addr", dmem_addr_o, e.addr);
            if (e.we) chk("req_wdata", dmem_wdata_o, e.wdata);
            chk("req_be", {28'd0, dmem_be_o}, {28'd0, e.be});
         end
      end
   end

   task automatic issue(input logic mw, input logic [2:0] rs, input logic [2:0] w,
                        input logic [31:0] addr, input logic [31:0] wd);
      valid_e_i = 1'b1; mem_write_e_i = mw; reg_write_e_i = ~mw;
      result_src_e_i = rs; width_src_e_i = w;
      alu_result_e_i = addr; write_data_e_i = wd; rd_e_i = 5'd7;
      stall_m_i = 1'b0;
      @(posedge clk); #1;
      valid_e_i = 1'b0; mem_write_e_i = 1'b0; reg_write_e_i = 1'b0;
      stall_m_i = 1'b1;
   endtask

   // cycle index c=0 is the first cycle after the instruction is latched; -1 = never
   task automatic wait_access(input int rdy_c, input int rv_c, input int fl_c,
                              input logic [31:0] rdata, output int busy);
      logic done;
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         dmem_ready_i  = (c == rdy_c);
         dmem_rvalid_i = (c == rv_c);
         flush_m_i     = (c == fl_c);
         dmem_rdata_i  = rdata;
         @(negedge clk);
         if (mem_busy_o) busy++;
         else if (c > rdy_c && c > rv_c && c > fl_c) done = 1'b1;
         @(posedge clk); #1;
         dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; flush_m_i = 1'b0;
      end
      if (!done) chk("access_timeout", 32'd1, 32'd0);
   endtask

   int busy;
   logic [2:0]  fw_rs [5] = '{3'b011, 3'b100, 3'b010, 3'b000, 3'b101};
   logic [31:0] fw_exp[5] = '{32'h1234_5000, 32'hDEAD_0000, 32'h0000_0104, 32'h0000_0055, 32'h0};

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; stall_m_i = 1'b1; flush_m_i = 1'b0;
      valid_e_i = 1'b0; reg_write_e_i = 1'b0; mem_write_e_i = 1'b0;
      alu_result_e_i = '0; write_data_e_i = '0; pc_target_e_i = '0;
      pc_plus4_e_i = '0; imm_ext_e_i = '0; rd_e_i = '0;
      width_src_e_i = '0; result_src_e_i = '0;
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_busy", {31'd0, mem_busy_o}, 32'd0);
      chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
      chk("rst_read_data", read_data_m_o, 32'd0);
      chk("rst_valid_m", {31'd0, valid_m_o}, 32'd0);
      chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
      chk("rst_forward", forward_data_m_o, 32'd0);
      @(posedge clk); #1;

      // SB to 0x1003
      req_q.push_back('{we: 1'b1, addr: 32'h1000, wdata: 32'hA5A5_A5A5, be: 4'b1000});
      issue(1'b1, 3'b000, 3'b010, 32'h1003, 32'h0000_00A5);
      wait_access(0, -1, -1, 32'h0, busy);
      chk("sb_busy", busy, 32'd1);

      // LH from 0x2002
      req_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0, be: 4'b1100});
      rd_q.push_back(32'hFFFF_8001);
      issue(1'b0, 3'b001, 3'b001, 32'h2002, 32'h0);
      wait_access(0, 2, -1, 32'h8001_1234, busy);
      chk("lh_busy", busy, 32'd3);

      // LBU from 0x01, minimum load latency
      req_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'b0010});
      rd_q.push_back(32'h0000_00FF);
      issue(1'b0, 3'b001, 3'b100, 32'h1, 32'h0);
      wait_access(0, 1, -1, 32'h0000_FF00, busy);
      chk("lbu_busy", busy, 32'd2);

      // LB from 0x03, negative byte
      req_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'b1000});
      rd_q.push_back(32'hFFFF_FF80);
      issue(1'b0, 3'b001, 3'b010, 32'h3, 32'h0);
      wait_access(0, 1, -1, 32'h8000_0000, busy);
      chk("lb_busy", busy, 32'd2);

      // misaligned LW: no request even with ready held high
      issue(1'b0, 3'b001, 3'b000, 32'h6, 32'h0);
      dmem_ready_i = 1'b1;
      @(negedge clk);
      chk("mis_flag", {31'd0, misalign_o}, 32'd1);
      chk("mis_busy", {31'd0, mem_busy_o}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("mis_req", {31'd0, dmem_req_o}, 32'd0);
      end
      @(posedge clk); #1 dmem_ready_i = 1'b0;

      // forwarding mux
      pc_target_e_i = 32'hDEAD_0000; pc_plus4_e_i = 32'h0000_0104; imm_ext_e_i = 32'h1234_5000;
      for (int i = 0; i < 5; i++) begin
         issue(1'b0, fw_rs[i], 3'b000, 32'h55, 32'h0);
         @(negedge clk);
         chk("forward", forward_data_m_o, fw_exp[i]);
         chk("fw_busy", {31'd0, mem_busy_o}, 32'd0);
         @(posedge clk); #1;
      end
      chk("rd_m", {27'd0, rd_m_o}, 32'd7);
      chk("pc_plus4_m", pc_plus4_m_o, 32'h0000_0104);
      chk("reg_write_m", {31'd0, reg_write_m_o}, 32'd1);

      // stray rvalid outside RSP leaves read data alone
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
      @(posedge clk); #1 dmem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("stray_rvalid", read_data_m_o, 32'hFFFF_FF80);
      @(posedge clk); #1;

      // LW flushed while in RSP: busy until rvalid, data discarded
      req_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, be: 4'b1111});
      rd_q.push_back(32'hFFFF_FF80);
      issue(1'b0, 3'b001, 3'b000, 32'h10, 32'h0);
      wait_access(0, 3, 1, 32'hCAFE_F00D, busy);
      chk("drain_busy", busy, 32'd4);

      // SW flushed in REQ before ready: request dropped
      issue(1'b1, 3'b000, 3'b000, 32'h40, 32'h1111_2222);
      wait_access(-1, -1, 1, 32'h0, busy);
      chk("flush_req_busy", busy, 32'd2);

      // SH with ready and flush on the same edge: store completes
      req_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h1234_1234, be: 4'b1100});
      issue(1'b1, 3'b000, 3'b001, 32'h22, 32'h0000_1234);
      wait_access(0, -1, 0, 32'h0, busy);
      chk("sh_flush_busy", busy, 32'd1);

      // reset while REQ is pending
      issue(1'b0, 3'b001, 3'b000, 32'h80, 32'h0);
      @(negedge clk);
      chk("pre_rst_req", {31'd0, dmem_req_o}, 32'd1);
      @(posedge clk); #1 reset_i = 1'b1;
      @(posedge clk); #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", {31'd0, dmem_req_o}, 32'd0);
      chk("rst_mid_busy", {31'd0, mem_busy_o}, 32'd0);
      chk("rst_mid_rdata", read_data_m_o, 32'd0);
      chk("rst_mid_be", {28'd0, dmem_be_o}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      chk("req_q_empty", req_q.size(), 32'd0);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
